// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the size-to-byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-data formatter: keeps the low 2^size bytes of the little-endian raw
// read and sign- or zero-extends them to 64 bits.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic sign_b;
  logic sign_h;
  logic sign_w;

  assign sign_b = !is_unsigned && raw[7];
  assign sign_h = !is_unsigned && raw[15];
  assign sign_w = !is_unsigned && raw[31];

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    data = raw;
    case (size)
      SZ_B:    data = {{56{sign_b}}, raw[7:0]};
      SZ_H:    data = {{48{sign_h}}, raw[15:0]};
      SZ_W:    data = {{32{sign_w}}, raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, fixed-latency data-memory responder with a little-endian byte array.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  state_e             state;
  state_e             state_nxt;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nxt;
  logic               go_access;

  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [1:0]         lat_size;
  logic               lat_unsigned;
  logic [63:0]        lat_wdata;

  logic               acc_write;
  logic [ADDR_W-1:0]  acc_addr;
  logic [1:0]         acc_size;
  logic               acc_unsigned;
  logic [63:0]        acc_wdata;
  logic [IDX_W-1:0]   acc_idx;
  logic [3:0]         acc_nbytes;
  logic               range_err;
  logic               misalign_err;
  logic               acc_err;
  logic [63:0]        raw_rdata;
  logic [63:0]        ext_rdata;

  logic [7:0]         mem [DEPTH_BYTES];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Next-state logic; go_access marks the edge that enters RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            go_access = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          go_access = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the accept edge itself, so
  // the request fields are used directly instead of the latched copies.
  always_comb begin
    if (state == IDLE) begin
      acc_write    = req_write;
      acc_addr     = req_addr;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_wdata    = req_wdata;
    end else begin
      acc_write    = lat_write;
      acc_addr     = lat_addr;
      acc_size     = lat_size;
      acc_unsigned = lat_unsigned;
      acc_wdata    = lat_wdata;
    end
  end

  assign acc_idx    = acc_addr[IDX_W-1:0];
  assign acc_nbytes = size_bytes(acc_size);

  // Widened by one bit so an address near 2^ADDR_W cannot wrap into range.
  assign range_err = ({1'b0, acc_addr} + (ADDR_W+1)'(acc_nbytes))
                     > (ADDR_W+1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_err = 1'b0;
    case (acc_size)
      SZ_H:    misalign_err = acc_addr[0];
      SZ_W:    misalign_err = |acc_addr[1:0];
      SZ_D:    misalign_err = |acc_addr[2:0];
      default: misalign_err = 1'b0;
    endcase
  end
`else
  assign misalign_err = 1'b0;
`endif

  assign acc_err = range_err || misalign_err;

  // Index wraps inside the array; wrapped lanes only matter for erroring
  // accesses, whose data is discarded.
  always_comb begin
    raw_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      raw_rdata[8*i +: 8] = mem[acc_idx + IDX_W'(i)];
    end
  end

  dmem_load_ext u_load_ext (
    .raw         (raw_rdata),
    .size        (acc_size),
    .is_unsigned (acc_unsigned),
    .data        (ext_rdata)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        lat_write    <= req_write;
        lat_addr     <= req_addr;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_wdata    <= req_wdata;
      end
      if (go_access) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? 64'd0 : ext_rdata;
      end
    end
  end

  // NOTE: the byte array is deliberately not reset; reset only blocks a pending store.
  always_ff @(posedge clk) begin
    if (!reset && go_access && acc_write && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < acc_nbytes) mem[acc_idx + IDX_W'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W      = 64;
  localparam int DEPTH_BYTES = 256;
  localparam int WAIT_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  // Issues one request and waits until resp_valid; leaves the DUT in RESP
  // with resp_ready low. Called and returning at #1 after a rising edge.
  task automatic txn(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata,
                     output logic [63:0] rdata, output logic err, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout addr=%h resp_valid=%b required 1", addr, resp_valid);
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (resp_rdata !== 64'd0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    checks++;
    if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dword();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h10, SZ_D, 1'b0, 64'h1122334455667788, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 64'd0) begin failures++; $display("FAIL sd_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    checks++;
    if (lat != WAIT_CYCLES) begin failures++; $display("FAIL sd_latency got=%0d exp=%0d", lat, WAIT_CYCLES); end
    finish_resp();
    txn(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin failures++; $display("FAIL ld_dword got err=%b rdata=%h exp err=0 rdata=1122334455667788", er, rd); end
    checks++;
    if (lat != WAIT_CYCLES) begin failures++; $display("FAIL ld_latency got=%0d exp=%0d", lat, WAIT_CYCLES); end
    finish_resp();
  endtask

  task automatic test_byte_ext();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h20, SZ_D, 1'b0, 64'd0, rd, er, lat);
    finish_resp();
    txn(1'b1, 64'h20, SZ_B, 1'b0, 64'hDEADBEEF_CAFE0080, rd, er, lat);
    finish_resp();
    txn(1'b0, 64'h20, SZ_B, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF80 || er !== 1'b0) begin failures++; $display("FAIL lb_signed got err=%b rdata=%h exp err=0 rdata=ffffffffffffff80", er, rd); end
    finish_resp();
    txn(1'b0, 64'h20, SZ_B, 1'b1, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000000000080) begin failures++; $display("FAIL lbu got=%h exp=0000000000000080", rd); end
    finish_resp();
    txn(1'b0, 64'h20, SZ_H, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000000000080) begin failures++; $display("FAIL lh got=%h exp=0000000000000080", rd); end
    finish_resp();
    txn(1'b0, 64'h10, SZ_W, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000055667788) begin failures++; $display("FAIL lw_pos got=%h exp=0000000055667788", rd); end
    finish_resp();
    txn(1'b0, 64'h12, SZ_H, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000000005566) begin failures++; $display("FAIL lh_12 got=%h exp=0000000000005566", rd); end
    finish_resp();
  endtask

  task automatic test_hold();
    logic [63:0] rd; logic er; int lat;
    txn(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, rd, er, lat);
    // Garbage request while busy must be ignored.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h10;
    req_size  = SZ_D;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122334455667788 || req_ready !== 1'b0)
        begin failures++; $display("FAIL hold_cycle%0d got valid=%b rdata=%h req_ready=%b exp 1/1122334455667788/0", i, resp_valid, resp_rdata, req_ready); end
    end
    req_valid = 1'b0;
    finish_resp();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL after_accept got req_ready=%b resp_valid=%b exp 1/0", req_ready, resp_valid); end
    txn(1'b0, 64'h10, SZ_D, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL ignored_store got=%h exp=1122334455667788", rd); end
    finish_resp();
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'hFE, SZ_H, 1'b0, 64'h000000000000BEEF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL sh_top got err=%b exp=0", er); end
    finish_resp();
    txn(1'b1, 64'hFE, SZ_W, 1'b0, 64'h0000000012345678, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL sw_cross got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    checks++;
    if (lat != WAIT_CYCLES) begin failures++; $display("FAIL err_latency got=%0d exp=%0d", lat, WAIT_CYCLES); end
    finish_resp();
    txn(1'b0, 64'hFE, SZ_H, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFBEEF || er !== 1'b0) begin failures++; $display("FAIL top_unchanged got err=%b rdata=%h exp err=0 rdata=ffffffffffffbeef", er, rd); end
    finish_resp();
    txn(1'b0, 64'hFF, SZ_B, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFFBE || er !== 1'b0) begin failures++; $display("FAIL lb_last got err=%b rdata=%h exp err=0 rdata=ffffffffffffffbe", er, rd); end
    finish_resp();
    txn(1'b0, 64'h1000, SZ_D, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL ld_far got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    finish_resp();
    txn(1'b0, 64'h8000000000000010, SZ_B, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL ld_highbit got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    finish_resp();
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h30, SZ_B, 1'b0, 64'h00000000000000AB, rd, er, lat);
    finish_resp();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h30;
    req_size  = SZ_B;
    req_wdata = 64'h0000000000000012;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL in_wait got req_ready=%b resp_valid=%b exp 0/0", req_ready, resp_valid); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL resp_in_reset cycle%0d got=%b exp=0", i, resp_valid); end
    end
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
    txn(1'b0, 64'h30, SZ_B, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFFAB || er !== 1'b0) begin failures++; $display("FAIL store_abandoned got err=%b rdata=%h exp err=0 rdata=ffffffffffffffab", er, rd); end
    finish_resp();
  endtask

  task automatic test_misalign();
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, 64'h40, SZ_D, 1'b0, 64'h8877665544332211, rd, er, lat);
    finish_resp();
    txn(1'b0, 64'h42, SZ_W, 1'b0, 64'd0, rd, er, lat);
    checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (er !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL lw_misalign got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
`else
    if (er !== 1'b0 || rd !== 64'h0000000066554433) begin failures++; $display("FAIL lw_misalign got err=%b rdata=%h exp err=0 rdata=0000000066554433", er, rd); end
`endif
    checks++;
    if (lat != WAIT_CYCLES) begin failures++; $display("FAIL misalign_latency got=%0d exp=%0d", lat, WAIT_CYCLES); end
    finish_resp();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    test_reset();
    test_dword();
    test_byte_ext();
    test_hold();
    test_range();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
